// File: rtl/pc_cfr_peak_detector.sv
// Peak detector for the peak-cancellation CFR path. It finds magnitude peaks above a
// threshold, enforces a minimum spacing between them, and emits the gain-scaled complex excess.
module pc_cfr_peak_detector #(
  parameter int DATA_WIDTH      = 16,
  parameter int GAIN_ADDR_WIDTH = 8,
  parameter int GAIN_WIDTH      = 16,
  parameter int HOLDOFF_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  data_i_in,
  input  logic signed [DATA_WIDTH-1:0]  data_q_in,
  output logic signed [DATA_WIDTH-1:0]  data_i_out,
  output logic signed [DATA_WIDTH-1:0]  data_q_out,
  output logic signed [DATA_WIDTH-1:0]  peak_i_out,
  output logic signed [DATA_WIDTH-1:0]  peak_q_out,
  output logic                          peak_phase_out,
  output logic                          peak_valid_out,
  input  logic                          ctrl_enable,
  input  logic [2*DATA_WIDTH-1:0]       ctrl_threshold,
  input  logic [HOLDOFF_WIDTH-1:0]      ctrl_holdoff,
  input  logic                          ctrl_gain_wr_en,
  input  logic [GAIN_ADDR_WIDTH-1:0]    ctrl_gain_wr_addr,
  input  logic [GAIN_WIDTH-1:0]         ctrl_gain_wr_data
);

  localparam int MW  = 2 * DATA_WIDTH;
  localparam int PW  = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int DLY = 7;
  localparam logic signed [PW-1:0] ROUND =
    {{(PW-GAIN_WIDTH){1'b0}}, 1'b1, {(GAIN_WIDTH-1){1'b0}}};

  // Sample delay line; tap 0 feeds the squarers, tap 3 lines up with m_cur_q.
  logic signed [DATA_WIDTH-1:0] dly_i_q [DLY];
  logic signed [DATA_WIDTH-1:0] dly_q_q [DLY];

  always_ff @(posedge clk) begin
    if (rst) begin
      dly_i_q[0] <= '0;
      dly_q_q[0] <= '0;
    end else begin
      dly_i_q[0] <= data_i_in;
      dly_q_q[0] <= data_q_in;
    end
  end

  generate
    for (genvar gi = 1; gi < DLY; gi++) begin : g_dly
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_i_q[gi] <= '0;
          dly_q_q[gi] <= '0;
        end else begin
          dly_i_q[gi] <= dly_i_q[gi-1];
          dly_q_q[gi] <= dly_q_q[gi-1];
        end
      end
    end
  endgenerate

  assign data_i_out = dly_i_q[DLY-1];
  assign data_q_out = dly_q_q[DLY-1];

  logic signed [MW-1:0] sq_i_q, sq_q_q;
  logic [MW-1:0]        m_prev_q, m_cur_q, m_next_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sq_i_q   <= '0;
      sq_q_q   <= '0;
      m_prev_q <= '0;
      m_cur_q  <= '0;
      m_next_q <= '0;
    end else begin
      sq_i_q   <= MW'(dly_i_q[0]) * MW'(dly_i_q[0]);
      sq_q_q   <= MW'(dly_q_q[0]) * MW'(dly_q_q[0]);
      m_next_q <= $unsigned(sq_i_q) + $unsigned(sq_q_q);
      m_cur_q  <= m_next_q;
      m_prev_q <= m_cur_q;
    end
  end

  logic                       candidate, accept, phase_d;
  logic [GAIN_ADDR_WIDTH-1:0] lut_idx;
  logic [HOLDOFF_WIDTH-1:0]   holdoff_q;

  // Strict rise on the left, non-strict on the right: a plateau picks its first sample.
  always_comb begin
    candidate = (m_cur_q > ctrl_threshold) && (m_cur_q > m_prev_q) && (m_cur_q >= m_next_q);
    accept    = candidate && ctrl_enable && (holdoff_q == '0);
    phase_d   = (m_next_q > m_prev_q);
    lut_idx   = m_cur_q[MW-1] ? '1 : m_cur_q[MW-2 -: GAIN_ADDR_WIDTH];
  end

  logic                         acc5_q, ph5_q;
  logic signed [DATA_WIDTH-1:0] pk_i_q, pk_q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      holdoff_q <= '0;
      acc5_q    <= 1'b0;
      ph5_q     <= 1'b0;
      pk_i_q    <= '0;
      pk_q_q    <= '0;
    end else begin
      if (!ctrl_enable)
        holdoff_q <= '0;
      else if (accept)
        holdoff_q <= ctrl_holdoff;
      else if (holdoff_q != '0)
        holdoff_q <= holdoff_q - HOLDOFF_WIDTH'(1);
      acc5_q <= accept;
      if (accept)
        ph5_q <= phase_d;
      pk_i_q <= dly_i_q[3];
      pk_q_q <= dly_q_q[3];
    end
  end

  // Gain table: no reset so it maps onto block RAM; reads return pre-write data.
  logic [GAIN_WIDTH-1:0] gain_mem [2**GAIN_ADDR_WIDTH];
  logic [GAIN_WIDTH-1:0] g_q;

  always_ff @(posedge clk) begin
    if (ctrl_gain_wr_en)
      gain_mem[ctrl_gain_wr_addr] <= ctrl_gain_wr_data;
  end

  always_ff @(posedge clk) begin
    g_q <= gain_mem[lut_idx];
  end

  logic signed [PW-1:0] prod_i_q, prod_q_q;
  logic                 acc6_q, ph6_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_i_q <= '0;
      prod_q_q <= '0;
      acc6_q   <= 1'b0;
      ph6_q    <= 1'b0;
    end else begin
      prod_i_q <= PW'(pk_i_q) * $signed(PW'({1'b0, g_q}));
      prod_q_q <= PW'(pk_q_q) * $signed(PW'({1'b0, g_q}));
      acc6_q   <= acc5_q;
      ph6_q    <= ph5_q;
    end
  end

  // g < 1, so the rounded product always fits DATA_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_valid_out <= 1'b0;
      peak_phase_out <= 1'b0;
      peak_i_out     <= '0;
      peak_q_out     <= '0;
    end else begin
      peak_valid_out <= acc6_q;
      if (acc6_q) begin
        peak_phase_out <= ph6_q;
        peak_i_out     <= DATA_WIDTH'((prod_i_q + ROUND) >>> GAIN_WIDTH);
        peak_q_out     <= DATA_WIDTH'((prod_q_q + ROUND) >>> GAIN_WIDTH);
      end
    end
  end

endmodule

// File: tb/tb_pc_cfr_peak_detector.sv
// Directed bench for pc_cfr_peak_detector: a table of short sample windows with
// hand-computed peak results, plus hand-written reset sequences.
module tb_pc_cfr_peak_detector;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] data_i_in, data_q_in, data_i_out, data_q_out;
  logic signed [15:0] peak_i_out, peak_q_out;
  logic               peak_phase_out, peak_valid_out;
  logic               ctrl_enable;
  logic [31:0]        ctrl_threshold;
  logic [7:0]         ctrl_holdoff;
  logic               ctrl_gain_wr_en;
  logic [7:0]         ctrl_gain_wr_addr;
  logic [15:0]        ctrl_gain_wr_data;

  always #5 clk = ~clk;

  pc_cfr_peak_detector #(
    .DATA_WIDTH(16), .GAIN_ADDR_WIDTH(8), .GAIN_WIDTH(16), .HOLDOFF_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst),
    .data_i_in(data_i_in), .data_q_in(data_q_in),
    .data_i_out(data_i_out), .data_q_out(data_q_out),
    .peak_i_out(peak_i_out), .peak_q_out(peak_q_out),
    .peak_phase_out(peak_phase_out), .peak_valid_out(peak_valid_out),
    .ctrl_enable(ctrl_enable), .ctrl_threshold(ctrl_threshold), .ctrl_holdoff(ctrl_holdoff),
    .ctrl_gain_wr_en(ctrl_gain_wr_en), .ctrl_gain_wr_addr(ctrl_gain_wr_addr),
    .ctrl_gain_wr_data(ctrl_gain_wr_data)
  );

  // Window of 8 samples, up to three nonzero (position -1 = unused).
  typedef struct {
    string       name;
    logic [31:0] thr;
    int          hold;
    logic        en;
    int          p0, i0, q0, p1, i1, q1, p2, i2, q2;
    int          ecnt, ef0, ef1, epi, epq, eph;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0, n_bad = 0;
  int   cyc, nv, v_pos0, v_pos1, v_pi, v_pq, v_ph;
  logic signed [15:0] hi_i [7];
  logic signed [15:0] hi_q [7];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, look at outputs 1ns after posedge.
  task automatic tick(input int i, input int q);
    data_i_in = 16'(i);
    data_q_in = 16'(q);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 6; k > 0; k--) begin
      hi_i[k] = rst ? 16'sd0 : hi_i[k-1];
      hi_q[k] = rst ? 16'sd0 : hi_q[k-1];
    end
    hi_i[0] = rst ? 16'sd0 : 16'(i);
    hi_q[0] = rst ? 16'sd0 : 16'(q);
    chk("data_i_out", data_i_out, hi_i[6]);
    chk("data_q_out", data_q_out, hi_q[6]);
    if (peak_valid_out) begin
      if (nv == 0) begin
        v_pos0 = cyc - 6;
        v_pi   = peak_i_out;
        v_pq   = peak_q_out;
        v_ph   = peak_phase_out;
      end else if (nv == 1) begin
        v_pos1 = cyc - 6;
      end
      nv++;
    end
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    ctrl_gain_wr_en   = 1'b1;
    ctrl_gain_wr_addr = 8'(a);
    ctrl_gain_wr_data = 16'(d);
    tick(0, 0);
    ctrl_gain_wr_en   = 1'b0;
  endtask

  task automatic add(input string nm, input logic [31:0] thr, input int hold, input logic en,
                     input int p0, input int i0, input int q0, input int p1, input int i1,
                     input int q1, input int p2, input int i2, input int q2, input int ecnt,
                     input int ef0, input int ef1, input int epi, input int epq, input int eph);
    vec_t v;
    v.name = nm; v.thr = thr; v.hold = hold; v.en = en;
    v.p0 = p0; v.i0 = i0; v.q0 = q0; v.p1 = p1; v.i1 = i1; v.q1 = q1;
    v.p2 = p2; v.i2 = i2; v.q2 = q2;
    v.ecnt = ecnt; v.ef0 = ef0; v.ef1 = ef1; v.epi = epi; v.epq = epq; v.eph = eph;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input vec_t v);
    int si, sq;
    ctrl_threshold = v.thr;
    ctrl_holdoff   = 8'(v.hold);
    ctrl_enable    = v.en;
    nv  = 0;
    cyc = -5;
    repeat (4) tick(0, 0);
    for (int w = 0; w < 8; w++) begin
      si = (w == v.p0) ? v.i0 : (w == v.p1) ? v.i1 : (w == v.p2) ? v.i2 : 0;
      sq = (w == v.p0) ? v.q0 : (w == v.p1) ? v.q1 : (w == v.p2) ? v.q2 : 0;
      tick(si, sq);
    end
    repeat (12) tick(0, 0);
    chk({v.name, " count"}, nv, v.ecnt);
    if (v.ecnt > 0 && nv > 0) begin
      chk({v.name, " pos"}, v_pos0, v.ef0);
      chk({v.name, " peak_i"}, v_pi, v.epi);
      chk({v.name, " peak_q"}, v_pq, v.epq);
      chk({v.name, " phase"}, v_ph, v.eph);
      chk({v.name, " peak_i hold"}, peak_i_out, v.epi);
    end
    if (v.ecnt > 1 && nv > 1)
      chk({v.name, " pos2"}, v_pos1, v.ef1);
    $display("vector %s: %0d valid(s)", v.name, nv);
  endtask

  initial begin
    rst = 1'b1;
    data_i_in = '0; data_q_in = '0;
    ctrl_enable = 1'b0; ctrl_threshold = '0; ctrl_holdoff = '0;
    ctrl_gain_wr_en = 1'b0; ctrl_gain_wr_addr = '0; ctrl_gain_wr_data = '0;
    for (int k = 0; k < 7; k++) begin
      hi_i[k] = '0;
      hi_q[k] = '0;
    end
    cyc = 0; nv = 0;
    @(negedge clk);
    repeat (3) tick(0, 0);
    chk("reset peak_i", peak_i_out, 0);
    chk("reset peak_q", peak_q_out, 0);
    chk("reset phase", peak_phase_out, 0);
    chk("reset valid", peak_valid_out, 0);
    rst = 1'b0;

    for (int a = 0; a < 256; a++)
      wr(a, (a == 107) ? 32'h4000 : (a == 255) ? 32'hFFFF : (a == 0) ? 32'h8000 : 0);

    //  name          thr           H  en  p0 i0      q0      p1 i1     q1 p2 i2     q2 cnt f0 f1 pi      pq      ph
    add("single",     32'h20000000, 0, 1,  0, 30000,  0,      -1, 0,     0, -1, 0,     0, 1,  0, -1, 7500,   0,      0);
    add("hold4 sp4",  32'h20000000, 4, 1,  0, 30000,  0,       4, 30000, 0, -1, 0,     0, 1,  0, -1, 7500,   0,      0);
    add("hold4 sp5",  32'h20000000, 4, 1,  0, 30000,  0,       5, 30000, 0, -1, 0,     0, 2,  0,  5, 7500,   0,      0);
    add("hold0 sp2",  32'h20000000, 0, 1,  0, 30000,  0,       2, 30000, 0, -1, 0,     0, 2,  0,  2, 7500,   0,      0);
    add("plateau",    32'h20000000, 0, 1,  1, 25000,  0,       2, 25000, 0, -1, 0,     0, 1,  1, -1, 0,      0,      1);
    add("ramp",       32'h20000000, 0, 1,  1, 20000,  0,       2, 30000, 0,  3, 10000, 0, 1,  2, -1, 7500,   0,      0);
    add("thr equal",  32'h35A4E900, 0, 1,  0, 30000,  0,      -1, 0,     0, -1, 0,     0, 0,  0, -1, 0,      0,      0);
    add("thr plus1",  32'h35A4E8FF, 0, 1,  0, 30000,  0,      -1, 0,     0, -1, 0,     0, 1,  0, -1, 7500,   0,      0);
    add("disabled",   32'h20000000, 0, 0,  0, 30000,  0,       4, 30000, 0, -1, 0,     0, 0,  0, -1, 0,      0,      0);
    add("corner",     32'h20000000, 0, 1,  0, -32768, -32768, -1, 0,     0, -1, 0,     0, 1,  0, -1, -32767, -32767, 0);
    add("round pos",  32'h00000000, 0, 1,  0, 3,      0,      -1, 0,     0, -1, 0,     0, 1,  0, -1, 2,      0,      0);
    add("round neg",  32'h00000000, 0, 1,  0, -3,     0,      -1, 0,     0, -1, 0,     0, 1,  0, -1, -1,     0,      0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // Reset while the peak sits in the accept register: it must never emerge.
    ctrl_threshold = 32'h20000000; ctrl_holdoff = '0; ctrl_enable = 1'b1;
    nv = 0; cyc = -5;
    repeat (4) tick(0, 0);
    tick(30000, 0);
    repeat (3) tick(0, 0);
    rst = 1'b1;
    tick(0, 0);
    chk("midrst peak_i", peak_i_out, 0);
    chk("midrst peak_q", peak_q_out, 0);
    chk("midrst phase", peak_phase_out, 0);
    chk("midrst valid", peak_valid_out, 0);
    rst = 1'b0;
    repeat (12) tick(0, 0);
    chk("midrst dropped", nv, 0);
    $display("reset mid-stream: %0d valid(s)", nv);

    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
